// File: rtl/emblem_seq_ctrl.sv
// Crest overlay sequencer: wipe-in, hold, blink, wipe-out on frame boundaries,
// plus a registered reveal-line mask on the emblem generator's rgb.
module emblem_seq_ctrl #(
    parameter int unsigned EMBLEM_Y0    = 144,
    parameter int unsigned EMBLEM_Y1    = 320,
    parameter int unsigned WIPE_STEP    = 4,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter int unsigned BLINK_FRAMES = 8,
    parameter int unsigned BLINK_COUNT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       start,
    input  logic       stop,
    input  logic [9:0] y,
    input  logic       de,
    input  logic [5:0] emblem_rgb,
    output logic       emblem_active,
    output logic [5:0] overlay_rgb,
    output logic [9:0] reveal_row,
    output logic       busy,
    output logic       done
);

    localparam int unsigned ROW_W   = 10;
    localparam int unsigned SUM_W   = ROW_W + 1;
    localparam int unsigned CNT_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned HALF_W  = $clog2(2 * BLINK_COUNT + 1);
    localparam logic [5:0]  TRANSPARENT = 6'b100001;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WIPE_IN  = 3'd1,
        HOLD     = 3'd2,
        BLINK    = 3'd3,
        WIPE_OUT = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    frame_cnt, cnt_nxt;
    logic [HALF_W-1:0]   half_cnt, half_nxt;
    logic                blink_on, blink_nxt;
    logic [ROW_W-1:0]    row_nxt, row_up, row_dn;
    logic [SUM_W-1:0]    row_sum;
    logic                done_nxt, active_nxt, busy_nxt;
    logic [5:0]          overlay_nxt;

    // Clamped reveal-line steps; the sum is one bit wider so it cannot wrap
    always_comb begin
        row_sum = {1'b0, reveal_row} + SUM_W'(WIPE_STEP);
        row_up  = (row_sum >= SUM_W'(EMBLEM_Y1)) ? ROW_W'(EMBLEM_Y1) : row_sum[ROW_W-1:0];
        row_dn  = (reveal_row < ROW_W'(EMBLEM_Y0 + WIPE_STEP)) ? ROW_W'(EMBLEM_Y0)
                                                               : reveal_row - ROW_W'(WIPE_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus frame-synchronous line/counter/blink updates
    always_comb begin
        state_nxt = state;
        row_nxt   = reveal_row;
        cnt_nxt   = frame_cnt;
        half_nxt  = half_cnt;
        blink_nxt = blink_on;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = WIPE_IN;
                    cnt_nxt   = '0;
                    half_nxt  = '0;
                    blink_nxt = 1'b1;
                end
            end
            WIPE_IN, HOLD, BLINK: begin
                if (stop) begin
                    state_nxt = WIPE_OUT;
                    cnt_nxt   = '0;
                    half_nxt  = '0;
                    blink_nxt = 1'b1;
                end else if (frame_start) begin
                    if (state == WIPE_IN) begin
                        if (reveal_row == ROW_W'(EMBLEM_Y1)) begin
                            state_nxt = HOLD;
                            cnt_nxt   = '0;
                        end else begin
                            row_nxt = row_up;
                        end
                    end else if (state == HOLD) begin
                        if (frame_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                            state_nxt = BLINK;
                            cnt_nxt   = '0;
                            half_nxt  = '0;
                            blink_nxt = 1'b0;
                        end else begin
                            cnt_nxt = frame_cnt + CNT_W'(1);
                        end
                    end else if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                        cnt_nxt = '0;
                        if (half_cnt == HALF_W'(2 * BLINK_COUNT - 1)) begin
                            state_nxt = WIPE_OUT;
                            blink_nxt = 1'b1;
                        end else begin
                            half_nxt  = half_cnt + HALF_W'(1);
                            blink_nxt = ~blink_on;
                        end
                    end else begin
                        cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end
            end
            WIPE_OUT: begin
                if (start) begin
                    state_nxt = WIPE_IN;
                    cnt_nxt   = '0;
                end else if (frame_start) begin
                    if (reveal_row == ROW_W'(EMBLEM_Y0)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        row_nxt = row_dn;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output next values; active tracks the state/blink being entered
    always_comb begin
        busy_nxt    = 1'b0;
        active_nxt  = 1'b0;
        overlay_nxt = TRANSPARENT;
        busy_nxt    = (state_nxt != IDLE);
        active_nxt  = (state_nxt != IDLE) && blink_nxt;
        if (emblem_active && de && (y < reveal_row))
            overlay_nxt = emblem_rgb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reveal_row    <= ROW_W'(EMBLEM_Y0);
            frame_cnt     <= '0;
            half_cnt      <= '0;
            blink_on      <= 1'b1;
            emblem_active <= 1'b0;
            overlay_rgb   <= TRANSPARENT;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            reveal_row    <= row_nxt;
            frame_cnt     <= cnt_nxt;
            half_cnt      <= half_nxt;
            blink_on      <= blink_nxt;
            emblem_active <= active_nxt;
            overlay_rgb   <= overlay_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

endmodule
